// File: rtl/tsu_queue_drain_arb.sv
// tsu_queue_drain_arb
// Drains the RX and TX tsu_queue timestamp FIFOs into a single ready/valid timestamp
// stream for the CPU-side register interface. Lives entirely in the q_rd_clk domain.
// Round-robin between the two queues, one FIFO read per transaction, with the read
// latency and the status settle time waited out before the next grant.
//
// Parameters
//   RD_LAT    cycles from q_rd_en high to valid q_rd_data (1..7)
//   STAT_LAT  settle cycles after a transfer before q_rd_stat is trusted (0..15)
//   CNT_W     width of the per-channel drain counters
// Ports
//   q_rd_clk, q_rst            clock, synchronous active-high reset
//   rx_en, tx_en               per-channel drain enables
//   {rx,tx}_q_rd_stat          queue fill level, nonzero = nonempty
//   {rx,tx}_q_rd_en            queue read strobes (never both high)
//   {rx,tx}_q_rd_data          queue read data
//   ts_valid/ts_ready          output handshake
//   ts_data, ts_src            captured entry and its source (0 = RX, 1 = TX)
//   rx_cnt, tx_cnt             wrapping counts of captured entries
//   busy                       high whenever the FSM is not in IDLE
module tsu_queue_drain_arb #(
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned STAT_LAT = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             q_rd_clk,
    input  logic             q_rst,
    input  logic             rx_en,
    input  logic             tx_en,
    input  logic [7:0]       rx_q_rd_stat,
    output logic             rx_q_rd_en,
    input  logic [47:0]      rx_q_rd_data,
    input  logic [7:0]       tx_q_rd_stat,
    output logic             tx_q_rd_en,
    input  logic [47:0]      tx_q_rd_data,
    output logic             ts_valid,
    input  logic             ts_ready,
    output logic [47:0]      ts_data,
    output logic             ts_src,
    output logic [CNT_W-1:0] rx_cnt,
    output logic [CNT_W-1:0] tx_cnt,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD,
        S_SETTLE
    } state_t;

    localparam logic [3:0] RD_LAT_M1   = 4'(RD_LAT - 1);
    localparam logic [3:0] STAT_LAT_M1 = 4'(STAT_LAT - 1);

    state_t           state_q;
    logic             prefer_tx_q;   // 1: TX wins the next tie
    logic             sel_tx_q;      // channel of the transaction in flight
    logic [3:0]       lat_q;
    logic             rx_rd_en_q;
    logic             tx_rd_en_q;
    logic             ts_valid_q;
    logic [47:0]      ts_data_q;
    logic             ts_src_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic             busy_q;

    logic rx_elig_d;
    logic tx_elig_d;
    logic grant_d;
    logic grant_tx_d;

    always_comb begin
        rx_elig_d  = rx_en & (|rx_q_rd_stat);
        tx_elig_d  = tx_en & (|tx_q_rd_stat);
        grant_d    = rx_elig_d | tx_elig_d;
        grant_tx_d = tx_elig_d & (~rx_elig_d | prefer_tx_q);
    end

    always_ff @(posedge q_rd_clk) begin
        if (q_rst) begin
            state_q     <= S_IDLE;
            prefer_tx_q <= 1'b0;
            sel_tx_q    <= 1'b0;
            lat_q       <= '0;
            rx_rd_en_q  <= 1'b0;
            tx_rd_en_q  <= 1'b0;
            ts_valid_q  <= 1'b0;
            ts_data_q   <= '0;
            ts_src_q    <= 1'b0;
            rx_cnt_q    <= '0;
            tx_cnt_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_d) begin
                        sel_tx_q    <= grant_tx_d;
                        prefer_tx_q <= ~grant_tx_d;
                        rx_rd_en_q  <= ~grant_tx_d;
                        tx_rd_en_q  <= grant_tx_d;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rx_rd_en_q <= 1'b0;
                    tx_rd_en_q <= 1'b0;
                    lat_q      <= RD_LAT_M1;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    // Last WAIT cycle is cycle c+RD_LAT, where read data is valid.
                    if (lat_q == '0) begin
                        ts_valid_q <= 1'b1;
                        ts_src_q   <= sel_tx_q;
                        if (sel_tx_q) begin
                            ts_data_q <= tx_q_rd_data;
                            tx_cnt_q  <= tx_cnt_q + CNT_W'(1);
                        end else begin
                            ts_data_q <= rx_q_rd_data;
                            rx_cnt_q  <= rx_cnt_q + CNT_W'(1);
                        end
                        state_q <= S_HOLD;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (ts_ready) begin
                        ts_valid_q <= 1'b0;
                        if (STAT_LAT == 0) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            lat_q   <= STAT_LAT_M1;
                            state_q <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (lat_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                default: begin
                    rx_rd_en_q <= 1'b0;
                    tx_rd_en_q <= 1'b0;
                    ts_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_q_rd_en = rx_rd_en_q;
    assign tx_q_rd_en = tx_rd_en_q;
    assign ts_valid   = ts_valid_q;
    assign ts_data    = ts_data_q;
    assign ts_src     = ts_src_q;
    assign rx_cnt     = rx_cnt_q;
    assign tx_cnt     = tx_cnt_q;
    assign busy       = busy_q;

endmodule
